ysyx_22050019_lsu: RTL and testbench

Load/store unit directly downstream of the execute stage. It consumes the execute stage's memory request (read/write enable, address, write data, byte mask) and converts it into a single-outstanding valid/ready transaction on an 8-byte data-memory port. It aligns bytes to the 64-bit bus and returns the load data to the execute stage's read-data input (ram_rdata_i). It stalls the core until the access completes, errors, or times out.

---
 rtl/ysyx_22050019_lsu_if.sv | 23 ++
 rtl/ysyx_22050019_lsu.sv | 159 +++++++++++++++
 tb/tb_ysyx_22050019_lsu.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050019_lsu_if.sv
// Data-memory port of the LSU: one request channel (valid/ready) and one
// response channel (valid only; the LSU always accepts responses).
interface ysyx_22050019_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        mem_resp_err;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_22050019_lsu.sv
// Load/store unit: turns the execute stage's memory request into a single
// outstanding 8-byte bus transaction and stalls the core until it finishes.
module ysyx_22050019_lsu #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_we,
    input  logic [63:0] ram_waddr,
    input  logic [63:0] ram_wdata,
    input  logic [7:0]  wmask,
    input  logic        ram_re,
    input  logic [63:0] ram_raddr,
    output logic [63:0] ram_rdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_err,
    ysyx_22050019_lsu_if.master mem
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam bit             TO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         off_q, off_d;
    logic [63:0]        addr_q, addr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [7:0]         wstrb_q, wstrb_d;
    logic               err_q, err_d;
    logic [63:0]        rdata_q, rdata_d;

    logic [15:0]        strb_wide;
    logic               timeout_hit;
    logic               take_resp;
    logic               abort;

    // Bits shifted past byte 7 mean the store straddles the 8-byte word.
    assign strb_wide   = {8'b0, wmask} << ram_waddr[2:0];
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    // NOTE: combinational process uses blocking '=' and assigns every output a
    // default first, so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        off_d     = off_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        lsu_stall = 1'b0;
        take_resp = 1'b0;
        abort     = 1'b0;
        mem.mem_req_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                lsu_stall = ram_we | ram_re;
                if (ram_we) begin
                    we_d    = 1'b1;
                    off_d   = ram_waddr[2:0];
                    addr_d  = {ram_waddr[63:3], 3'b000};
                    wdata_d = ram_wdata << {ram_waddr[2:0], 3'b000};
                    wstrb_d = strb_wide[7:0];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (|strb_wide[15:8]) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (ram_re) begin
                    we_d    = 1'b0;
                    off_d   = ram_raddr[2:0];
                    addr_d  = {ram_raddr[63:3], 3'b000};
                    wdata_d = '0;
                    wstrb_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                lsu_stall         = 1'b1;
                mem.mem_req_valid = 1'b1;
                cnt_d             = cnt_q + CNT_W'(1);
                if (mem.mem_req_ready && mem.mem_resp_valid) take_resp = 1'b1;
                else if (timeout_hit)                        abort     = 1'b1;
                else if (mem.mem_req_ready)                  state_d   = S_WAIT;
            end
            S_WAIT: begin
                lsu_stall = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (mem.mem_resp_valid) take_resp = 1'b1;
                else if (timeout_hit)   abort     = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (take_resp) begin
            state_d = S_DONE;
            err_d   = mem.mem_resp_err;
            if (!we_q)
                rdata_d = mem.mem_resp_err ? 64'd0 : (mem.mem_resp_rdata >> {off_q, 3'b000});
        end
        if (abort) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
        end
    end

    // NOTE: synchronous reset clears every register, including the wide data
    // holding registers, so nothing from an aborted access leaks afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem.mem_req_we    = we_q;
    assign mem.mem_req_addr  = addr_q;
    assign mem.mem_req_wdata = wdata_q;
    assign mem.mem_req_wstrb = wstrb_q;

    assign ram_rdata = rdata_q;
    assign lsu_done  = (state_q == S_DONE);
    assign lsu_err   = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
// Self-checking bench for ysyx_22050019_lsu: directed vector table, a reset
// sequence mid-access, and randomized accesses checked against a spec model.
module tb_ysyx_22050019_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_we, ram_re;
    logic [63:0] ram_waddr, ram_wdata, ram_raddr;
    logic [7:0]  wmask;
    logic [63:0] ram_rdata;
    logic        lsu_stall, lsu_done, lsu_err;

    ysyx_22050019_lsu_if mem_if ();

    ysyx_22050019_lsu #(.TIMEOUT_CYC(T), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .wmask     (wmask),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .lsu_stall (lsu_stall),
        .lsu_done  (lsu_done),
        .lsu_err   (lsu_err),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we, re;
        logic [63:0] waddr, wdata, raddr;
        logic [7:0]  wmask;
        int          d1, d2;
        logic [63:0] resp_rdata;
        logic        resp_err;
        int          exp_done;
        int          exp_vcyc;
        int          exp_hs;
        logic        exp_err;
        logic [63:0] exp_rdata;
        logic        exp_we;
        logic [63:0] exp_addr, exp_wdata;
        logic [7:0]  exp_wstrb;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic re, input logic [63:0] waddr, input logic [63:0] wdata,
        input logic [7:0] wm, input logic [63:0] raddr, input int d1, input int d2,
        input logic [63:0] rd, input logic re_err,
        input int e_done, input int e_vcyc, input int e_hs, input logic e_err,
        input logic [63:0] e_rdata, input logic [63:0] e_addr, input logic [7:0] e_strb,
        input logic [63:0] e_wdata);
        vec_t v;
        v.we = we; v.re = re; v.waddr = waddr; v.wdata = wdata; v.wmask = wm; v.raddr = raddr;
        v.d1 = d1; v.d2 = d2; v.resp_rdata = rd; v.resp_err = re_err;
        v.exp_done = e_done; v.exp_vcyc = e_vcyc; v.exp_hs = e_hs; v.exp_err = e_err;
        v.exp_rdata = e_rdata; v.exp_we = we; v.exp_addr = e_addr;
        v.exp_wstrb = e_strb; v.exp_wdata = e_wdata;
        return v;
    endfunction

    // Reference: expected results from the access rules, in terms of how many
    // cycles memory takes (d1 cycles before ready, d2 after the handshake).
    function automatic vec_t model(input vec_t v, input logic [63:0] prev);
        vec_t   r;
        logic [63:0] a;
        int     off, k;
        r = v;
        a = v.we ? v.waddr : v.raddr;
        off = int'(a[2:0]);
        r.exp_we    = v.we;
        r.exp_addr  = a - 64'(off);
        r.exp_wstrb = 8'((int'(v.wmask) << off) % 256);
        r.exp_wdata = v.wdata << (8 * off);
        k = v.d1 + 1 + v.d2;
        if (v.we && ((int'(v.wmask) << off) > 255)) begin
            r.exp_done = 1; r.exp_vcyc = 0; r.exp_hs = 0;
            r.exp_err = 1'b1; r.exp_rdata = prev;
        end else if (k <= T) begin
            r.exp_done = k + 1; r.exp_vcyc = v.d1 + 1; r.exp_hs = 1;
            r.exp_err = v.resp_err;
            if (v.we)            r.exp_rdata = prev;
            else if (v.resp_err) r.exp_rdata = 64'd0;
            else                 r.exp_rdata = v.resp_rdata >> (8 * off);
        end else begin
            r.exp_done = T + 1;
            r.exp_vcyc = (v.d1 + 1 < T) ? v.d1 + 1 : T;
            r.exp_hs   = (v.d1 + 1 <= T) ? 1 : 0;
            r.exp_err  = 1'b1; r.exp_rdata = 64'd0;
        end
        return r;
    endfunction

    task automatic idle_inputs();
        ram_we = 1'b0; ram_re = 1'b0;
        ram_waddr = '0; ram_wdata = '0; ram_raddr = '0; wmask = '0;
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_rdata = '0;
        mem_if.mem_resp_err   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   done_cyc = -1;
        int   vcyc = 0, hs_cnt = 0, wcnt = 0;
        bit   hs_seen = 0, resp_sent = 0, fld_bad = 0, hs;
        logic got_err = 1'b0;
        logic [63:0] got_rdata = '0, first_addr = '0;
        @(negedge clk);
        ram_we = v.we; ram_re = v.re;
        ram_waddr = v.waddr; ram_wdata = v.wdata; wmask = v.wmask; ram_raddr = v.raddr;
        #1;
        check({tag, " stall_idle"}, 64'(lsu_stall), 64'd1);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            mem_if.mem_resp_valid = 1'b0;
            mem_if.mem_req_ready  = 1'b0;
            if (lsu_done) begin
                done_cyc  = cyc;
                got_err   = lsu_err;
                got_rdata = ram_rdata;
                check({tag, " stall_done"}, 64'(lsu_stall), 64'd0);
                check({tag, " valid_in_done"}, 64'(mem_if.mem_req_valid), 64'd0);
                break;
            end
            check({tag, " stall_busy"}, 64'(lsu_stall), 64'd1);
            hs = 0;
            if (mem_if.mem_req_valid) begin
                if (vcyc == 0) first_addr = mem_if.mem_req_addr;
                vcyc++;
                if (mem_if.mem_req_addr !== v.exp_addr || mem_if.mem_req_we !== v.exp_we) fld_bad = 1;
                if (v.exp_we && (mem_if.mem_req_wstrb !== v.exp_wstrb ||
                                 mem_if.mem_req_wdata !== v.exp_wdata)) fld_bad = 1;
                mem_if.mem_req_ready = (vcyc - 1 == v.d1);
                hs = mem_if.mem_req_ready;
            end
            if (hs) begin hs_cnt++; hs_seen = 1; wcnt = 0; end
            if (hs_seen && !resp_sent && wcnt == v.d2) begin
                mem_if.mem_resp_valid = 1'b1;
                mem_if.mem_resp_rdata = v.resp_rdata;
                mem_if.mem_resp_err   = v.resp_err;
                resp_sent = 1;
            end
            if (hs_seen) wcnt++;
        end
        ram_we = 1'b0; ram_re = 1'b0;
        mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0;
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
        check({tag, " err"}, 64'(got_err), 64'(v.exp_err));
        check({tag, " rdata"}, got_rdata, v.exp_rdata);
        check({tag, " valid_cycles"}, 64'(vcyc), 64'(v.exp_vcyc));
        check({tag, " handshakes"}, 64'(hs_cnt), 64'(v.exp_hs));
        if (v.exp_vcyc > 0) check({tag, " req_addr"}, first_addr, v.exp_addr);
        check({tag, " req_fields_stable"}, 64'(fld_bad), 64'd0);
    endtask

    vec_t table_v[$];
    vec_t v;
    logic [63:0] prev;
    logic [7:0] masks [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //        we re waddr          wdata        wm     raddr          d1  d2 resp_rdata             rerr done vcyc hs err exp_rdata             exp_addr       strb   exp_wdata
        table_v.push_back(mk(0, 1, 64'h0, 64'h0, 8'h00, 64'h80000010, 0, 1, 64'h1122334455667788, 0, 3, 1, 1, 0, 64'h1122334455667788, 64'h80000010, 8'h00, 64'h0));
        table_v.push_back(mk(1, 0, 64'h80000006, 64'hABCD, 8'h03, 64'h0, 0, 0, 64'h0, 0, 2, 1, 1, 0, 64'h1122334455667788, 64'h80000000, 8'hC0, 64'hABCD000000000000));
        table_v.push_back(mk(1, 0, 64'h80000007, 64'hABCD, 8'h03, 64'h0, 0, 0, 64'h0, 0, 1, 0, 0, 1, 64'h1122334455667788, 64'h80000000, 8'h80, 64'h0));
        table_v.push_back(mk(0, 1, 64'h0, 64'h0, 8'h00, 64'h80000020, 99, 0, 64'h0, 0, 5, 4, 0, 1, 64'h0, 64'h80000020, 8'h00, 64'h0));
        table_v.push_back(mk(0, 1, 64'h0, 64'h0, 8'h00, 64'h80000005, 1, 0, 64'hFFEEDDCCBBAA9988, 0, 3, 2, 1, 0, 64'h0000000000FFEEDD, 64'h80000000, 8'h00, 64'h0));
        table_v.push_back(mk(1, 1, 64'h80000008, 64'h55, 8'h01, 64'h80000100, 0, 0, 64'hDEADDEADDEADDEAD, 0, 2, 1, 1, 0, 64'h0000000000FFEEDD, 64'h80000008, 8'h01, 64'h55));
        table_v.push_back(mk(0, 1, 64'h0, 64'h0, 8'h00, 64'h80000003, 0, 0, 64'h1234, 1, 2, 1, 1, 1, 64'h0, 64'h80000000, 8'h00, 64'h0));
        table_v.push_back(mk(0, 1, 64'h0, 64'h0, 8'h00, 64'h80000018, 1, 2, 64'hCAFEF00DDEADBEEF, 0, 5, 2, 1, 0, 64'hCAFEF00DDEADBEEF, 64'h80000018, 8'h00, 64'h0));
        table_v.push_back(mk(1, 0, 64'h80000001, 64'h1, 8'hFF, 64'h0, 0, 0, 64'h0, 0, 1, 0, 0, 1, 64'hCAFEF00DDEADBEEF, 64'h80000000, 8'hFE, 64'h0));
        table_v.push_back(mk(1, 0, 64'h80000004, 64'h89ABCDEF, 8'h0F, 64'h0, 2, 1, 64'h0, 0, 5, 3, 1, 0, 64'hCAFEF00DDEADBEEF, 64'h80000000, 8'hF0, 64'h89ABCDEF00000000));
        table_v.push_back(mk(0, 1, 64'h0, 64'h0, 8'h00, 64'h80000028, 0, 9, 64'h77, 0, 5, 1, 1, 1, 64'h0, 64'h80000028, 8'h00, 64'h0));
        table_v.push_back(mk(0, 1, 64'h0, 64'h0, 8'h00, 64'h8000003F, 0, 0, 64'hAB00000000000000, 0, 2, 1, 1, 0, 64'h00000000000000AB, 64'h80000038, 8'h00, 64'h0));

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset done", 64'(lsu_done), 64'd0);
        check("reset err", 64'(lsu_err), 64'd0);
        check("reset rdata", ram_rdata, 64'd0);
        check("reset valid", 64'(mem_if.mem_req_valid), 64'd0);
        check("reset stall", 64'(lsu_stall), 64'd0);
        rst_n = 1'b1;

        foreach (table_v[i]) run_vec(table_v[i], $sformatf("vec%0d", i));

        // Reset while waiting for a response; the late response must be dropped.
        @(negedge clk);
        ram_re = 1'b1; ram_raddr = 64'h80000040;
        @(negedge clk);
        check("rst_seq valid_req", 64'(mem_if.mem_req_valid), 64'd1);
        mem_if.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_if.mem_req_ready = 1'b0;
        check("rst_seq valid_wait", 64'(mem_if.mem_req_valid), 64'd0);
        check("rst_seq stall_wait", 64'(lsu_stall), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ram_re = 1'b0;
        #1;
        check("rst_seq stall", 64'(lsu_stall), 64'd0);
        check("rst_seq rdata_cleared", ram_rdata, 64'd0);
        mem_if.mem_resp_valid = 1'b1; mem_if.mem_resp_rdata = 64'h5555; mem_if.mem_resp_err = 1'b0;
        @(negedge clk);
        mem_if.mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_seq no_done", 64'(lsu_done), 64'd0);
            check("rst_seq no_valid", 64'(mem_if.mem_req_valid), 64'd0);
            check("rst_seq rdata", ram_rdata, 64'd0);
            @(negedge clk);
        end

        prev = 64'd0;
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            v.we = (kind != 1); v.re = (kind != 0);
            v.waddr = 64'h80000000 + 64'($urandom_range(0, 255));
            v.raddr = 64'h80000000 + 64'($urandom_range(0, 255));
            v.wdata = {$urandom, $urandom};
            v.wmask = masks[$urandom_range(0, 3)];
            v.d1 = $urandom_range(0, 3);
            v.d2 = $urandom_range(0, 3);
            if (v.we && v.d1 + 1 + v.d2 > T) v.d2 = T - 1 - v.d1;
            v.resp_rdata = {$urandom, $urandom};
            v.resp_err = ($urandom_range(0, 5) == 0);
            v = model(v, prev);
            run_vec(v, $sformatf("rnd%0d", n));
            prev = v.exp_rdata;
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
